// File: rtl/health_bar_ctrl_pkg.sv
// Shared types and default colours for the health bar block.
package health_pkg;

    // Player condition tracked by the controller.
    typedef enum logic [1:0] {
        ALIVE  = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } state_e;

    // 12-bit RGB (4:4:4) segment colours.
    localparam logic [11:0] COL_FULL_DEF  = 12'h00F;
    localparam logic [11:0] COL_LOST_DEF  = 12'h333;
    localparam logic [11:0] COL_FLASH_DEF = 12'hFFF;

endpackage

// File: rtl/health_bar_ctrl_if.sv
// Game-logic / video side of the health bar: events in, status and pixel colour out.
interface health_bar_ctrl_if #(
    parameter int MAX_HEALTH = 3
);
    localparam int HW = $clog2(MAX_HEALTH + 1);

    logic          frame_tick;
    logic          hit;
    logic [HW-1:0] damage;
    logic          heal;
    logic [HW-1:0] heal_amt;
    logic          revive;
    logic [9:0]    x;
    logic [9:0]    y;
    logic [HW-1:0] health;
    logic          dead;
    logic          invuln;
    logic          hit_ack;
    logic          pixel_en;
    logic [11:0]   pixel_rgb;

    // Driver of game events and pixel coordinates.
    modport master (
        output frame_tick, hit, damage, heal, heal_amt, revive, x, y,
        input  health, dead, invuln, hit_ack, pixel_en, pixel_rgb
    );

    // The health bar controller itself.
    modport slave (
        input  frame_tick, hit, damage, heal, heal_amt, revive, x, y,
        output health, dead, invuln, hit_ack, pixel_en, pixel_rgb
    );

endinterface

// File: rtl/health_bar_render.sv
// Registered x/y-to-colour lookup for the segmented health bar.
module health_bar_render
    import health_pkg::*;
#(
    parameter int          MAX_HEALTH = 3,
    parameter int          SEG_W      = 60,
    parameter int          BAR_X0     = 420,
    parameter int          BAR_Y0     = 460,
    parameter int          BAR_H      = 10,
    parameter logic [11:0] COL_FULL   = COL_FULL_DEF,
    parameter logic [11:0] COL_LOST   = COL_LOST_DEF,
    parameter logic [11:0] COL_FLASH  = COL_FLASH_DEF,
    localparam int         HW         = $clog2(MAX_HEALTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [HW-1:0] health,
    input  logic          phase,
    output logic          pixel_en,
    output logic [11:0]   pixel_rgb
);

    logic        en_d;
    logic        en_q;
    logic [11:0] rgb_d;
    logic [11:0] rgb_q;

    // Segment hit test: the loop unrolls into compares against constant edges, no divider.
    always_comb begin
        en_d  = 1'b0;
        rgb_d = '0;
        if (int'(y) >= BAR_Y0 && int'(y) < BAR_Y0 + BAR_H) begin
            for (int i = 0; i < MAX_HEALTH; i++) begin
                if (int'(x) >= BAR_X0 + i * SEG_W && int'(x) < BAR_X0 + (i + 1) * SEG_W) begin
                    en_d = 1'b1;
                    if (i >= int'(health)) begin
                        rgb_d = COL_LOST;
                    end else if (phase) begin
                        rgb_d = COL_FLASH;
                    end else begin
                        rgb_d = COL_FULL;
                    end
                end
            end
        end
    end

    // One-cycle output register; blank while in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_q  <= 1'b0;
            rgb_q <= '0;
        end else begin
            en_q  <= en_d;
            rgb_q <= rgb_d;
        end
    end

    assign pixel_en  = en_q;
    assign pixel_rgb = rgb_q;

endmodule

// File: rtl/health_bar_ctrl.sv
// Health state machine (alive / invulnerable / dead) with blink timing and bar renderer.
module health_bar_ctrl
    import health_pkg::*;
#(
    parameter int          MAX_HEALTH    = 3,
    parameter int          SEG_W         = 60,
    parameter int          BAR_X0        = 420,
    parameter int          BAR_Y0        = 460,
    parameter int          BAR_H         = 10,
    parameter int          INVULN_FRAMES = 60,
    parameter int          BLINK_FRAMES  = 4,
    parameter logic [11:0] COL_FULL      = COL_FULL_DEF,
    parameter logic [11:0] COL_LOST      = COL_LOST_DEF,
    parameter logic [11:0] COL_FLASH     = COL_FLASH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    health_bar_ctrl_if.slave   bus
);

    localparam int HW = $clog2(MAX_HEALTH + 1);
    localparam int FW = $clog2(INVULN_FRAMES + 1);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [HW-1:0]        MAX_H = HW'(MAX_HEALTH);
    localparam logic signed [HW+1:0] MAX_S = (HW + 2)'(MAX_HEALTH);

    if (MAX_HEALTH < 1 || MAX_HEALTH > 15) begin : g_bad_max_health
        $error("health_bar_ctrl: MAX_HEALTH must be in 1..15");
    end
    if (BAR_X0 + MAX_HEALTH * SEG_W > 640) begin : g_bad_bar_width
        $error("health_bar_ctrl: bar extends past x=640");
    end

    // Clamp a signed health candidate into 0..MAX_HEALTH.
    function automatic logic [HW-1:0] sat_health(input logic signed [HW+1:0] v);
        if (v[HW+1] || v == '0) begin
            return '0;
        end else if (v >= MAX_S) begin
            return MAX_H;
        end
        return v[HW-1:0];
    endfunction

    state_e                  state_d, state_q;
    logic [HW-1:0]           health_d, health_q;
    logic [FW-1:0]           frame_d, frame_q;
    logic [BW-1:0]           blink_cnt_d, blink_cnt_q;
    logic                    blink_d, blink_q;
    logic                    ack_d, ack_q;
    logic                    dead_q, invuln_q;
    logic                    hit_eff;
    logic signed [HW+1:0]    dmg_s, heal_s, sum_hit, sum_heal;

    // Next-state: revive first, then hit/heal by state, then invulnerability timing.
    always_comb begin
        state_d     = state_q;
        health_d    = health_q;
        frame_d     = frame_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        ack_d       = 1'b0;
        hit_eff     = bus.hit && (bus.damage != '0);
        dmg_s       = hit_eff  ? signed'({2'b00, bus.damage})   : '0;
        heal_s      = bus.heal ? signed'({2'b00, bus.heal_amt}) : '0;
        sum_hit     = signed'({2'b00, health_q}) - dmg_s + heal_s;
        sum_heal    = signed'({2'b00, health_q}) + heal_s;
        if (bus.revive) begin
            state_d     = ALIVE;
            health_d    = MAX_H;
            frame_d     = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else begin
            unique case (state_q)
                ALIVE: begin
                    if (hit_eff || bus.heal) begin
                        health_d = sat_health(sum_hit);
                    end
                    if (hit_eff) begin
                        ack_d       = 1'b1;
                        state_d     = (sat_health(sum_hit) == '0) ? DEAD : INVULN;
                        frame_d     = '0;
                        blink_cnt_d = '0;
                        blink_d     = 1'b0;
                    end
                end
                INVULN: begin
                    if (bus.heal) begin
                        health_d = sat_health(sum_heal);
                    end
                    if (bus.frame_tick) begin
                        if (frame_q == FW'(INVULN_FRAMES - 1)) begin
                            state_d     = ALIVE;
                            frame_d     = '0;
                            blink_cnt_d = '0;
                            blink_d     = 1'b0;
                        end else begin
                            frame_d = frame_q + 1'b1;
                            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                                blink_cnt_d = '0;
                                blink_d     = ~blink_q;
                            end else begin
                                blink_cnt_d = blink_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                DEAD: begin
                end
                default: state_d = ALIVE;
            endcase
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ALIVE;
            health_q    <= MAX_H;
            frame_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            ack_q       <= 1'b0;
            dead_q      <= 1'b0;
            invuln_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            health_q    <= health_d;
            frame_q     <= frame_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            ack_q       <= ack_d;
            dead_q      <= (state_d == DEAD);
            invuln_q    <= (state_d == INVULN);
        end
    end

    assign bus.health  = health_q;
    assign bus.dead    = dead_q;
    assign bus.invuln  = invuln_q;
    assign bus.hit_ack = ack_q;

    health_bar_render #(
        .MAX_HEALTH (MAX_HEALTH),
        .SEG_W      (SEG_W),
        .BAR_X0     (BAR_X0),
        .BAR_Y0     (BAR_Y0),
        .BAR_H      (BAR_H),
        .COL_FULL   (COL_FULL),
        .COL_LOST   (COL_LOST),
        .COL_FLASH  (COL_FLASH)
    ) u_render (
        .clk        (clk),
        .rst        (rst),
        .x          (bus.x),
        .y          (bus.y),
        .health     (health_q),
        .phase      (blink_q),
        .pixel_en   (bus.pixel_en),
        .pixel_rgb  (bus.pixel_rgb)
    );

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Scoreboard bench for health_bar_ctrl with default parameters.
module tb_health_bar_ctrl;

    localparam int MAXH = 3;
    localparam int HW   = $clog2(MAXH + 1);

    localparam int K_HEALTH = 0;
    localparam int K_DEAD   = 1;
    localparam int K_INVULN = 2;
    localparam int K_PEN    = 3;
    localparam int K_RGB    = 4;
    localparam int K_ACK    = 5;

    typedef struct {
        string name;
        int    kind;
        int    val;
    } exp_t;

    logic clk;
    logic rst;
    logic pix_req;
    logic pix_vld_d;
    int   checks;
    int   errors;
    exp_t st_q[$];
    exp_t pix_q[$];
    int   ack_q[$];

    health_bar_ctrl_if #(.MAX_HEALTH(MAXH)) bus_if ();

    health_bar_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // A pixel request's result is valid one clock after the coordinates are sampled.
    always @(posedge clk) pix_vld_d <= pix_req;

    // Monitor: pixel results, hit_ack pulses and queued state expectations.
    always @(negedge clk) begin
        exp_t e;
        int   act;
        if (pix_vld_d) begin
            if (pix_q.size() == 0) begin
                check("pixel_unexpected", 1, 0);
            end else begin
                e = pix_q.pop_front();
                check({"pix_", e.name}, int'({bus_if.pixel_en, bus_if.pixel_rgb}), e.val);
            end
        end
        if (bus_if.hit_ack) begin
            if (ack_q.size() == 0) begin
                check("hit_ack_unexpected", 1, 0);
            end else begin
                check("hit_ack_health", int'(bus_if.health), ack_q.pop_front());
            end
        end
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            case (e.kind)
                K_HEALTH: act = int'(bus_if.health);
                K_DEAD:   act = int'(bus_if.dead);
                K_INVULN: act = int'(bus_if.invuln);
                K_PEN:    act = int'(bus_if.pixel_en);
                K_RGB:    act = int'(bus_if.pixel_rgb);
                default:  act = int'(bus_if.hit_ack);
            endcase
            check(e.name, act, e.val);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_st(input string name, input int kind, input int val);
        exp_t e;
        e.name = name;
        e.kind = kind;
        e.val  = val;
        st_q.push_back(e);
    endtask

    task automatic expect_st(input string name, input int h, input int d, input int inv, input int ack);
        push_st({name, "_health"}, K_HEALTH, h);
        push_st({name, "_dead"},   K_DEAD,   d);
        push_st({name, "_invuln"}, K_INVULN, inv);
        push_st({name, "_ack"},    K_ACK,    ack);
    endtask

    // One-cycle event pulse; ack_health >= 0 means a hit_ack with that health is expected.
    task automatic apply(input bit h, input int dmg, input bit hl, input int amt,
                         input bit rv, input bit ft, input int ack_health);
        bus_if.hit        = h;
        bus_if.damage     = HW'(dmg);
        bus_if.heal       = hl;
        bus_if.heal_amt   = HW'(amt);
        bus_if.revive     = rv;
        bus_if.frame_tick = ft;
        if (ack_health >= 0) ack_q.push_back(ack_health);
        tick();
        bus_if.hit        = 1'b0;
        bus_if.damage     = '0;
        bus_if.heal       = 1'b0;
        bus_if.heal_amt   = '0;
        bus_if.revive     = 1'b0;
        bus_if.frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0, 1, -1);
    endtask

    task automatic probe(input string name, input int px, input int py, input int en, input int rgb);
        exp_t e;
        e.name = name;
        e.kind = K_PEN;
        e.val  = (en << 12) | rgb;
        bus_if.x = 10'(px);
        bus_if.y = 10'(py);
        pix_q.push_back(e);
        pix_req = 1'b1;
        tick();
        pix_req = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        pix_req = 1'b0;
        rst = 1'b0;
        bus_if.hit = 1'b0;
        bus_if.damage = '0;
        bus_if.heal = 1'b0;
        bus_if.heal_amt = '0;
        bus_if.revive = 1'b0;
        bus_if.frame_tick = 1'b0;
        bus_if.x = '0;
        bus_if.y = '0;
        tick();
        tick();
        expect_st("reset", 3, 0, 0, 0);
        push_st("reset_pixel_en", K_PEN, 0);
        push_st("reset_pixel_rgb", K_RGB, 0);
        tick();
        rst = 1'b1;
        tick();

        // Hit, invulnerability window and blink.
        apply(1, 1, 0, 0, 0, 0, 2);
        expect_st("hit1", 2, 0, 1, 1);
        tick();
        expect_st("ack_pulse", 2, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            probe($sformatf("blink%0d", k), 425, 465, 1, (k < 4) ? 12'h00F : 12'hFFF);
            frames(1);
        end
        apply(1, 1, 0, 0, 0, 0, -1);
        expect_st("hit_in_invuln", 2, 0, 1, 0);
        frames(51);
        expect_st("invuln_tick59", 2, 0, 1, 0);
        frames(1);
        expect_st("invuln_tick60", 2, 0, 0, 0);

        // Bar geometry with health=2.
        probe("x419", 419, 465, 0, 12'h000);
        probe("x420", 420, 465, 1, 12'h00F);
        probe("x479", 479, 465, 1, 12'h00F);
        probe("x480", 480, 465, 1, 12'h00F);
        probe("x539", 539, 465, 1, 12'h00F);
        probe("x540", 540, 465, 1, 12'h333);
        probe("x599", 599, 465, 1, 12'h333);
        probe("x600", 600, 465, 0, 12'h000);
        probe("y459", 425, 459, 0, 12'h000);
        probe("y469", 425, 469, 1, 12'h00F);
        probe("y470", 425, 470, 0, 12'h000);

        // Death, ignored events, revive.
        apply(1, 3, 0, 0, 0, 0, 0);
        expect_st("kill", 0, 1, 0, 1);
        probe("dead_seg0", 425, 465, 1, 12'h333);
        apply(0, 0, 1, 2, 0, 0, -1);
        expect_st("heal_dead", 0, 1, 0, 0);
        apply(1, 1, 0, 0, 0, 0, -1);
        expect_st("hit_dead", 0, 1, 0, 0);
        apply(0, 0, 0, 0, 1, 0, -1);
        expect_st("revive", 3, 0, 0, 0);

        // Zero damage, combined hit+heal, saturation, revive priority.
        apply(1, 0, 0, 0, 0, 0, -1);
        expect_st("dmg0", 3, 0, 0, 0);
        apply(1, 3, 1, 1, 0, 0, 1);
        expect_st("hit3_heal1", 1, 0, 1, 1);
        frames(60);
        expect_st("alive_h1", 1, 0, 0, 0);
        apply(1, 1, 1, 2, 0, 0, 2);
        expect_st("hit1_heal2", 2, 0, 1, 1);
        apply(0, 0, 1, 3, 0, 0, -1);
        expect_st("heal_sat", 3, 0, 1, 0);
        apply(0, 0, 1, 3, 0, 0, -1);
        expect_st("heal_sat_full", 3, 0, 1, 0);
        apply(1, 3, 0, 0, 1, 0, -1);
        expect_st("revive_prio", 3, 0, 0, 0);
        apply(1, 3, 1, 3, 0, 0, 3);
        expect_st("hit3_heal3", 3, 0, 1, 1);

        // Reset in the middle of invulnerability, then an immediate hit.
        apply(0, 0, 0, 0, 1, 0, -1);
        expect_st("revive2", 3, 0, 0, 0);
        apply(1, 2, 0, 0, 0, 0, 1);
        expect_st("hit2", 1, 0, 1, 1);
        probe("pre_rst_seg0", 425, 465, 1, 12'h00F);
        tick();
        rst = 1'b0;
        expect_st("rst_mid", 3, 0, 0, 0);
        push_st("rst_mid_pixel_en", K_PEN, 0);
        tick();
        rst = 1'b1;
        apply(1, 1, 0, 0, 0, 0, 2);
        expect_st("post_rst_hit", 2, 0, 1, 1);
        tick();
        tick();

        check("ack_queue_drained", ack_q.size(), 0);
        check("pix_queue_drained", pix_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
